cosine_job_arbiter: RTL and testbench
=====================================

Name: cosine_job_arbiter

Overview:
- Shares one cosine-similarity micro-sequenced engine between NUM_REQ requesters, one job at a time.
- Grants jobs round-robin and latches the granted operand vectors.
- Sequences the engine through a clear pulse, a held start, and a wait for done.
- Returns the 16-bit result, or a timeout error, to the owning requester over a valid/ready response channel.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 64, max cycles in RUN before the job is aborted with error
CNT_W, 16, width of the completed-job counter

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester job request
req_ready  out  NUM_REQ  one-hot job accept
req_a_vec  in  NUM_REQ*32  flattened A vectors, requester i at [32i+31:32i]
req_b_vec  in  NUM_REQ*32  flattened B vectors, same packing
resp_valid  out  NUM_REQ  one-hot result valid to the job owner
resp_ready  in  NUM_REQ  per-requester result accept
resp_data  out  16  cosine similarity result; 0 when resp_err
resp_err  out  1  job timed out
eng_reset  out  1  engine reset (restarts its micro-PC, clears its sticky done)
eng_start  out  1  engine start
eng_a_vec  out  32  latched A operand
eng_b_vec  out  32  latched B operand
eng_done  in  1  engine done (sticky until eng_reset)
eng_result  in  16  engine cosine_similarity output
busy  out  1  high in any state other than IDLE
jobs_done  out  CNT_W  count of successful jobs; saturates at all-ones

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, rr_ptr=0, owner=0, timeout counter=0, operand regs=0, result regs=0, jobs_done=0.
  - All outputs 0 except eng_reset=1.
  - eng_reset = reset OR (state==CLEAR).
- State IDLE:
  - req_ready = grant one-hot when any req_valid is set, otherwise 0; req_ready is combinational from req_valid and rr_ptr.
  - Grant = first set req_valid at or after rr_ptr, searching cyclically.
  - On accept (req_valid[g] & req_ready[g]): latch the A/B slices of g and owner=g, set rr_ptr=(g+1) mod NUM_REQ, go to CLEAR.
  - No requests: stay in IDLE, rr_ptr unchanged.
- State CLEAR (exactly 1 cycle): eng_reset=1, eng_start=0, then go to RUN.
  - This guarantees the engine's sticky done and micro-PC are cleared before each job.
- State RUN:
  - eng_start=1 (held high) and the timeout counter increments each cycle, starting from 0.
  - If eng_done=1: capture eng_result into resp_data, resp_err=0, go to RESP.
  - Else if counter==TIMEOUT_CYC-1: resp_data=0, resp_err=1, go to RESP.
  - eng_done takes priority when it coincides with timeout expiry.
- State RESP:
  - resp_valid[owner]=1; resp_data and resp_err stay stable; eng_start=0.
  - On resp_ready[owner]: go to IDLE; if resp_err==0, increment jobs_done with saturation.
  - resp_ready on non-owner lines is ignored.
  - No new grant while in CLEAR/RUN/RESP; req_ready=0 there.
  - A requester may present a new request while its own response is pending; it competes in the next IDLE.
- Latency, ideal case (accept in cycle 0): CLEAR in cycle 1, RUN from cycle 2.
  - resp_valid is asserted 1 cycle after eng_done is sampled.
  - Minimum request-to-request spacing is 4 cycles.
- Width rules: eng_a_vec/eng_b_vec are the direct 32-bit latched slices; resp_data is the unmodified 16-bit eng_result.
- Operand regs do not change between accept and return to IDLE, even if req_*_vec changes.
- Reset mid-operation (any state): returns to IDLE next cycle.
  - eng_reset asserted during reset; pending response discarded; jobs_done cleared.

Decomposition:
- Shared package cos_arb_pkg:
  - state enum {IDLE, CLEAR, RUN, RESP} (2 bits)
  - localparams VEC_W=32, RES_W=16
  - function for extracting slice i of a flattened vector
- Sub-module rr_arbiter (parameter N):
  - inputs req[N] and ptr[$clog2(N)]; outputs one-hot grant[N] and grant_idx.
  - Purely combinational; the pointer register stays in cosine_job_arbiter.

Test Plan:
1. Single job: req_valid=4'b0001, A=32'h04030201, B=32'h08070605; engine model asserts done with result 16'h0059 after 30 RUN cycles -> req_ready=4'b0001 for 1 cycle, eng_reset one cycle, eng_a_vec=32'h04030201, resp_valid=4'b0001 with resp_data=16'h0059, resp_err=0, jobs_done=1.
2. Round-robin fairness: all four req_valid held high, engine done after 5 cycles, resp_ready=1 -> grant order 0,1,2,3,0,1; no requester granted twice before all others are served.
3. Timeout: engine never asserts done, TIMEOUT_CYC=64 -> resp_err=1, resp_data=0 exactly 64 RUN cycles after entry; jobs_done unchanged; the next job starts with a CLEAR pulse.
4. Response backpressure: resp_ready[owner]=0 for 20 cycles while req_valid[2]=1 -> resp_valid and resp_data stable, req_ready=0 throughout; grant to 2 in the cycle after resp_ready rises.
5. Coincident events: eng_done=1 in the same cycle the counter hits TIMEOUT_CYC-1 -> resp_err=0 with the captured result. Separately, resp_ready pulsed on a non-owner line -> ignored.
6. Reset mid-RUN: reset=1 for 1 cycle at RUN cycle 10 -> next cycle state IDLE, all resp_valid=0, jobs_done=0, rr_ptr=0, eng_reset=1 during reset; a new request to requester 3 is served normally afterwards.

Source files
------------

// File: rtl/cos_arb_pkg.sv
// Shared types and helpers for the cosine-engine job arbiter.
package cos_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int VEC_W   = 32;
  localparam int RES_W   = 16;
  localparam int MAX_REQ = 8;

  // Flattened vectors are zero-extended to MAX_REQ slices so one helper serves any NUM_REQ.
  function automatic logic [VEC_W-1:0] vec_slice(input logic [MAX_REQ*VEC_W-1:0] flat,
                                                 input logic [2:0] idx);
    return flat[idx*VEC_W +: VEC_W];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, cyclically.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  // Scan N candidates starting at ptr; the first hit wins.
  always_comb begin
    logic found;
    int unsigned cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end else begin
        cand = cand;
      end
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand[$clog2(N)-1:0];
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/cosine_job_arbiter.sv
// Round-robin job arbiter sharing one cosine-similarity engine between NUM_REQ requesters.
module cosine_job_arbiter
  import cos_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*32-1:0]    req_a_vec,
  input  logic [NUM_REQ*32-1:0]    req_b_vec,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [15:0]              resp_data,
  output logic                     resp_err,
  output logic                     eng_reset,
  output logic                     eng_start,
  output logic [31:0]              eng_a_vec,
  output logic [31:0]              eng_b_vec,
  input  logic                     eng_done,
  input  logic [15:0]              eng_result,
  output logic                     busy,
  output logic [CNT_W-1:0]         jobs_done
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e                   r_state;
  logic [PW-1:0]            r_rr_ptr;
  logic [PW-1:0]            r_owner;
  logic [TW-1:0]            r_tcnt;
  logic [VEC_W-1:0]         r_a;
  logic [VEC_W-1:0]         r_b;
  logic [RES_W-1:0]         r_resp_data;
  logic                     r_resp_err;
  logic [CNT_W-1:0]         r_jobs_done;

  logic [NUM_REQ-1:0]       w_grant;
  logic [PW-1:0]            w_grant_idx;
  logic [MAX_REQ*VEC_W-1:0] w_a_flat;
  logic [MAX_REQ*VEC_W-1:0] w_b_flat;
  logic                     w_accept;
  logic                     w_take;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // Widen the flattened operand buses so the package slice helper can index them.
  always_comb begin
    w_a_flat = '0;
    w_b_flat = '0;
    w_a_flat[NUM_REQ*VEC_W-1:0] = req_a_vec;
    w_b_flat[NUM_REQ*VEC_W-1:0] = req_b_vec;
  end

  assign w_accept = (r_state == ST_IDLE) && (|req_valid);
  assign w_take   = (r_state == ST_RESP) && resp_ready[r_owner];

  // Control outputs are forced quiet while reset is held, even before the state register clears.
  always_comb begin
    resp_valid = '0;
    if ((r_state == ST_RESP) && !reset) begin
      resp_valid[r_owner] = 1'b1;
    end else begin
      resp_valid = '0;
    end
  end

  assign req_ready = ((r_state == ST_IDLE) && !reset) ? w_grant : '0;
  assign eng_reset = reset || (r_state == ST_CLEAR);
  assign eng_start = (r_state == ST_RUN) && !reset;
  assign busy      = (r_state != ST_IDLE) && !reset;
  assign eng_a_vec = r_a;
  assign eng_b_vec = r_b;
  assign resp_data = r_resp_data;
  assign resp_err  = r_resp_err;
  assign jobs_done = r_jobs_done;

  // Job sequencer: grant, clear the engine, run with timeout, hold the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_tcnt      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
      r_jobs_done <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= vec_slice(w_a_flat, 3'(w_grant_idx));
            r_b     <= vec_slice(w_b_flat, 3'(w_grant_idx));
            r_owner <= w_grant_idx;
            if (w_grant_idx == PW'(NUM_REQ - 1)) begin
              r_rr_ptr <= '0;
            end else begin
              r_rr_ptr <= w_grant_idx + PW'(1);
            end
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_tcnt  <= '0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          // A done arriving on the final timeout cycle still counts as success.
          if (eng_done) begin
            r_resp_data <= eng_result;
            r_resp_err  <= 1'b0;
            r_state     <= ST_RESP;
          end else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        ST_RESP: begin
          if (w_take) begin
            r_state <= ST_IDLE;
            if (!r_resp_err && (r_jobs_done != {CNT_W{1'b1}})) begin
              r_jobs_done <= r_jobs_done + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cosine_job_arbiter.sv
// Randomized scoreboard bench for cosine_job_arbiter with a behavioural engine and reference model.
module tb_cosine_job_arbiter;

  localparam int N  = 4;
  localparam int TO = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [N*32-1:0] req_a_vec, req_b_vec;
  logic [15:0]   resp_data, eng_result;
  logic          resp_err, eng_reset, eng_start, eng_done, busy;
  logic [31:0]   eng_a_vec, eng_b_vec;
  logic [CW-1:0] jobs_done;

  always #5 clk = ~clk;

  cosine_job_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a_vec(req_a_vec), .req_b_vec(req_b_vec),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .eng_reset(eng_reset), .eng_start(eng_start),
    .eng_a_vec(eng_a_vec), .eng_b_vec(eng_b_vec),
    .eng_done(eng_done), .eng_result(eng_result),
    .busy(busy), .jobs_done(jobs_done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Engine latency in start cycles is carried in the low 7 bits of A (0 behaves as 1).
  function automatic int lat_of(input logic [31:0] a);
    return (a[6:0] == 7'd0) ? 1 : int'(a[6:0]);
  endfunction

  function automatic logic [15:0] cos_of(input logic [31:0] a, input logic [31:0] b);
    return a[15:0] ^ b[31:16];
  endfunction

  // Behavioural engine: sticky done after lat_of(A) start cycles, cleared by eng_reset.
  int  e_cnt;
  logic e_done;
  always @(posedge clk) begin
    if (eng_reset) begin
      e_cnt  <= 0;
      e_done <= 1'b0;
    end else if (eng_start) begin
      e_cnt <= e_cnt + 1;
      if (e_cnt + 1 >= lat_of(eng_a_vec)) e_done <= 1'b1;
    end
  end
  assign eng_done   = e_done;
  assign eng_result = cos_of(eng_a_vec, eng_b_vec);

  typedef struct {
    int          owner;
    logic [15:0] data;
    logic        err;
    int          vcyc;
  } exp_t;
  exp_t exp_q[$];

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Reference model: whole-job timing from accept, pointer and job count, checked every cycle.
  bit          m_busy = 0;
  bit          m_err = 0;
  int          m_ptr = 0, m_owner = 0, m_w = 0, m_wait = 0;
  logic [31:0] m_a, m_b;
  logic [15:0] m_jobs = 16'd0;

  always @(negedge clk) begin : model
    int g, lat, run;
    exp_t e;
    logic [N-1:0] exp_rdy;
    if (reset) begin
      check("rst_eng_reset", eng_reset, 1'b1);
      check("rst_req_ready", req_ready, 4'b0000);
      check("rst_resp_valid", resp_valid, 4'b0000);
      check("rst_busy", busy, 1'b0);
      m_busy = 0; m_ptr = 0; m_jobs = 16'd0; m_wait = 0; m_w = 0;
      exp_q.delete();
    end else begin
      g = m_busy ? -1 : rr_pick(req_valid, m_ptr);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      check("busy", busy, m_busy);
      check("jobs_done", jobs_done, m_jobs);
      check("eng_reset", eng_reset, m_busy && (m_wait == m_w - 1));
      check("eng_start", eng_start, m_busy && (m_wait >= 1) && (m_wait <= m_w - 2));
      if (m_busy) begin
        check("eng_a_vec", eng_a_vec, m_a);
        check("eng_b_vec", eng_b_vec, m_b);
      end
      if (g >= 0) begin
        m_busy  = 1;
        m_owner = g;
        m_ptr   = (g + 1) % N;
        m_a     = req_a_vec[32*g +: 32];
        m_b     = req_b_vec[32*g +: 32];
        lat     = lat_of(m_a);
        run     = (lat < TO) ? lat : TO - 1;
        m_err   = (lat >= TO);
        m_w     = 3 + run;
        m_wait  = m_w - 1;
        e.owner = g;
        e.err   = m_err;
        e.data  = m_err ? 16'd0 : cos_of(m_a, m_b);
        e.vcyc  = cyc + m_w;
        exp_q.push_back(e);
      end else if (m_busy) begin
        if (m_wait > 0) m_wait--;
        else if (resp_ready[m_owner]) begin
          m_busy = 0;
          if (!m_err && m_jobs != 16'hFFFF) m_jobs++;
        end
      end
    end
  end

  // Monitor: compares each presented response against the scoreboard head.
  bit mon_prev = 0;
  always @(negedge clk) begin : monitor
    exp_t f;
    logic [N-1:0] ov;
    if (reset) begin
      mon_prev = 0;
    end else if (resp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", resp_valid, 4'b0000);
      end else begin
        f = exp_q[0];
        ov = '0;
        ov[f.owner] = 1'b1;
        check("resp_owner", resp_valid, ov);
        check("resp_data", resp_data, f.data);
        check("resp_err", resp_err, f.err);
        if (!mon_prev) check("resp_latency", cyc, f.vcyc);
        if (resp_ready[f.owner]) begin
          void'(exp_q.pop_front());
          mon_prev = 0;
        end else begin
          mon_prev = 1;
        end
      end
    end else begin
      mon_prev = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a_vec[32*i +: 32] = a;
    req_b_vec[32*i +: 32] = b;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300 && m_busy; k++) tick(1);
    if (m_busy) check("wait_idle_timeout", 1'b1, 1'b0);
  endtask

  task automatic wait_resp();
    int k;
    for (k = 0; k < 300 && !(m_busy && m_wait == 0); k++) tick(1);
    if (!(m_busy && m_wait == 0)) check("wait_resp_timeout", 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] rnd_a(input int lat);
    logic [31:0] r;
    r = $urandom;
    r[6:0] = 7'(lat);
    return r;
  endfunction

  initial begin
    int pick, lat;
    reset = 1'b1; req_valid = '0; resp_ready = '0; req_a_vec = '0; req_b_vec = '0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Single job from requester 0.
    set_vec(0, 32'h04030201, 32'h08070605);
    req_valid = 4'b0001; resp_ready = 4'b1111;
    tick(1);
    req_valid = 4'b0000;
    wait_idle();

    // All requesters contend; round-robin order follows from the model pointer.
    for (int i = 0; i < N; i++) set_vec(i, rnd_a(5), $urandom);
    req_valid = 4'b1111;
    tick(54);
    req_valid = 4'b0000;
    wait_idle();

    // Timeout, then a normal job that must start with a clear pulse.
    set_vec(0, rnd_a(127), $urandom);
    req_valid = 4'b0001;
    tick(1);
    req_valid = 4'b0000;
    wait_idle();
    set_vec(1, rnd_a(3), $urandom);
    req_valid = 4'b0010;
    tick(1);
    req_valid = 4'b0000;
    wait_idle();

    // Done coinciding with timeout expiry, under backpressure with non-owner ready pulses.
    set_vec(0, rnd_a(63), $urandom);
    set_vec(2, rnd_a(4), $urandom);
    resp_ready = 4'b1110;
    req_valid = 4'b0001;
    tick(1);
    req_valid = 4'b0100;
    wait_resp();
    tick(20);
    resp_ready = 4'b1111;
    tick(3);
    req_valid = 4'b0000;
    wait_idle();

    // Reset in the middle of a long RUN, then pointer restart and requester 3 served.
    set_vec(1, rnd_a(100), $urandom);
    req_valid = 4'b0010;
    tick(1);
    req_valid = 4'b0000;
    tick(11);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_vec(i, rnd_a(2), $urandom);
    req_valid = 4'b1111;
    tick(1);
    req_valid = 4'b1000;
    wait_idle();
    tick(1);
    req_valid = 4'b0000;
    wait_idle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        pick = $urandom_range(0, 19);
        if (pick < 16)       lat = $urandom_range(1, 12);
        else if (pick == 16) lat = 62;
        else if (pick == 17) lat = 63;
        else if (pick == 18) lat = 64;
        else                 lat = 0;
        set_vec(i, rnd_a(lat), $urandom);
      end
      req_valid  = N'($urandom_range(0, 15));
      resp_ready = N'($urandom_range(0, 15));
      reset      = ($urandom_range(0, 799) == 0);
      tick(1);
    end
    reset = 1'b0; req_valid = '0; resp_ready = 4'b1111;
    tick(1);
    wait_idle();
    tick(2);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
